// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: DATA stores queue bytes in a small FIFO, STATUS loads poll it.
// Store at edge N on an idle link drives the start bit at edge N+1; stores to a full FIFO are dropped and flag overflow.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        tx
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t            state;
  logic [7:0]        shreg;
  logic [BAUD_W-1:0] baud;
  logic [2:0]        bitcnt;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  logic data_hit, status_hit;
  logic data_wr, status_wr;
  logic full, empty, busy;
  logic push, pop;
  logic [7:0] cnt8;
  logic [31:0] status;
  logic unused_bits;

  assign hit        = (addr[31:3] == BASE_ADDR[31:3]);
  assign data_hit   = hit & ~addr[2];
  assign status_hit = hit & addr[2];
  assign data_wr    = we & data_hit;
  assign status_wr  = we & status_hit;

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);
  assign busy  = (state != ST_IDLE);

  // Full is judged before this edge's pop, so a store into a full FIFO is lost even if a pop frees a slot.
  assign push = data_wr & ~full;
  assign pop  = (state == ST_IDLE) & ~empty;

  assign cnt8   = 8'(count);
  assign status = {20'b0, cnt8, overflow, empty, full, busy};

  always_comb begin
    rdata = 32'h0;
    if (re && status_hit)
      rdata = status;
  end

  assign unused_bits = ^{addr[1:0], wdata[31:8]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= 8'h00;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata[7:0];
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (data_wr && full)
        overflow <= 1'b1;
      else if (status_wr && wdata[3])
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      tx     <= 1'b1;
      shreg  <= 8'h00;
      baud   <= '0;
      bitcnt <= 3'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shreg <= mem[rd_ptr];
            tx    <= 1'b0;
            baud  <= '0;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (baud == BAUD_LAST) begin
            baud   <= '0;
            bitcnt <= 3'd0;
            tx     <= shreg[0];
            state  <= ST_DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        ST_DATA: begin
          if (baud == BAUD_LAST) begin
            baud <= '0;
            if (bitcnt == 3'd7) begin
              tx    <= 1'b1;
              state <= ST_STOP;
            end else begin
              shreg  <= {1'b0, shreg[7:1]};
              tx     <= shreg[1];
              bitcnt <= bitcnt + 1'b1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        ST_STOP: begin
          if (baud == BAUD_LAST) begin
            baud  <= '0;
            state <= ST_IDLE;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: frame timing, FIFO fill/overflow, decode and async reset.
module tb_mmio_uart_tx;

  localparam int CPB = 16;
  localparam logic [31:0] DATA_A = 32'h0000_0400;
  localparam logic [31:0] STAT_A = 32'h0000_0404;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [31:0] rdata;
  logic        hit;
  logic        tx;

  int checks = 0;
  int errors = 0;

  mmio_uart_tx #(
    .BASE_ADDR   (32'h0000_0400),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .wdata(wdata),
    .we   (we),
    .re   (re),
    .rdata(rdata),
    .hit  (hit),
    .tx   (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called 1ns after an edge; the store is sampled at the next edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic h);
    addr = a;
    re   = 1'b1;
    #1;
    d  = rdata;
    h  = hit;
    re = 1'b0;
  endtask

  task automatic wait_fall(input int budget, output int n, output logic got);
    got = 1'b0;
    n   = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (!tx) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget, output logic got);
    logic [31:0] s;
    logic h;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      rd(STAT_A, s, h);
      if (!s[0]) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // Entered just after the edge that drove the start bit; checks first and last cycle of every bit.
  task automatic check_frame(input string tag, input logic [7:0] b);
    logic exp_bit;
    logic [31:0] s;
    logic h;
    for (int i = 0; i < 10; i++) begin
      exp_bit = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
      check($sformatf("%s bit%0d head", tag, i), {31'b0, tx}, {31'b0, exp_bit});
      if (i == 5) begin
        rd(STAT_A, s, h);
        check($sformatf("%s busy", tag), {31'b0, s[0]}, 32'h1);
      end
      repeat (CPB - 1) @(posedge clk);
      #1;
      check($sformatf("%s bit%0d tail", tag, i), {31'b0, tx}, {31'b0, exp_bit});
      @(posedge clk);
      #1;
    end
  endtask

  logic [31:0] rv;
  logic        rh;
  int          n;
  logic        got;

  initial begin
    reset = 1'b1;
    addr  = 32'h0;
    wdata = 32'h0;
    we    = 1'b0;
    re    = 1'b0;
    #10;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // reset state
    check("reset tx", {31'b0, tx}, 32'h1);
    rd(STAT_A, rv, rh);
    check("reset status", rv, 32'h0000_0004);

    // single byte frame and latency
    wr(DATA_A, 32'h0000_00A5);
    check("a5 tx before fall", {31'b0, tx}, 32'h1);
    rd(STAT_A, rv, rh);
    check("a5 queued status", rv, 32'h0000_0010);
    wait_fall(5, n, got);
    check("a5 fall", {31'b0, got}, 32'h1);
    check("a5 latency", n, 32'd1);
    check_frame("a5", 8'hA5);
    rd(STAT_A, rv, rh);
    check("a5 idle status", rv, 32'h0000_0004);

    // decode
    rd(32'h0000_0408, rv, rh);
    check("0x408 hit", {31'b0, rh}, 32'h0);
    check("0x408 rdata", rv, 32'h0);
    rd(32'h0000_03FC, rv, rh);
    check("0x3fc hit", {31'b0, rh}, 32'h0);
    check("0x3fc rdata", rv, 32'h0);
    rd(DATA_A, rv, rh);
    check("data read", rv, 32'h0);
    addr = STAT_A;
    re   = 1'b0;
    #1;
    check("status re=0 rdata", rdata, 32'h0);
    check("status re=0 hit", {31'b0, hit}, 32'h1);
    wr(32'h0000_0401, 32'hFFFF_FF5A);
    wait_fall(5, n, got);
    check("0x401 fall", {31'b0, got}, 32'h1);
    check("0x401 latency", n, 32'd1);
    check_frame("5a", 8'h5A);

    // fill while busy, overflow, back-to-back frames
    wr(DATA_A, 32'h0000_00C3);
    wait_fall(5, n, got);
    check("c3 fall", {31'b0, got}, 32'h1);
    wr(DATA_A, 32'h11);
    wr(DATA_A, 32'h22);
    wr(DATA_A, 32'h33);
    wr(DATA_A, 32'h44);
    wr(DATA_A, 32'h55);
    rd(STAT_A, rv, rh);
    check("full ovf status", rv, 32'h0000_004B);
    wr(STAT_A, 32'h0000_0008);
    rd(STAT_A, rv, rh);
    check("ovf cleared", rv, 32'h0000_0043);
    wait_idle(200, got);
    check("c3 done", {31'b0, got}, 32'h1);
    wait_fall(5, n, got);
    check("11 gap", n, 32'd1);
    check_frame("11", 8'h11);
    wait_fall(5, n, got);
    check("22 gap", n, 32'd1);
    check_frame("22", 8'h22);
    wait_fall(5, n, got);
    check("33 gap", n, 32'd1);
    check_frame("33", 8'h33);
    wait_fall(5, n, got);
    check("44 gap", n, 32'd1);
    check_frame("44", 8'h44);
    wait_fall(200, n, got);
    check("55 dropped", {31'b0, got}, 32'h0);

    // push+pop at count=2 with pointer wrap
    wr(DATA_A, 32'h61);
    wait_fall(5, n, got);
    check("61 fall", {31'b0, got}, 32'h1);
    wr(DATA_A, 32'h62);
    wr(DATA_A, 32'h63);
    rd(STAT_A, rv, rh);
    check("count2 status", rv, 32'h0000_0021);
    wait_idle(200, got);
    check("61 done", {31'b0, got}, 32'h1);
    wr(DATA_A, 32'h64);
    rd(STAT_A, rv, rh);
    check("push+pop status", rv, 32'h0000_0021);
    check_frame("62", 8'h62);
    wait_fall(5, n, got);
    check("63 gap", n, 32'd1);
    check_frame("63", 8'h63);
    wait_fall(5, n, got);
    check("64 gap", n, 32'd1);
    check_frame("64", 8'h64);
    rd(STAT_A, rv, rh);
    check("wrap idle status", rv, 32'h0000_0004);

    // async reset mid-frame
    wr(DATA_A, 32'h0F);
    wait_fall(5, n, got);
    check("0f fall", {31'b0, got}, 32'h1);
    repeat (3 * CPB) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("reset mid-frame tx", {31'b0, tx}, 32'h1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    rd(STAT_A, rv, rh);
    check("post reset status", rv, 32'h0000_0004);
    wait_fall(200, n, got);
    check("no frame after reset", {31'b0, got}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
